// File: rtl/mac_argmax_core.sv
// MAC lanes computing (a-c)*b, a three-level pipelined ternary adder tree,
// and a sequential argmax over the first N_ARG activation lanes.
module mac_argmax_core #(
   parameter int N_MAC = 27,
   parameter int IN_W  = 8,
   parameter int MAC_W = 24,
   parameter int SUM_W = 24,
   parameter int N_ARG = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    acc,
   input  logic [N_MAC*IN_W-1:0]   a,
   input  logic [N_MAC*IN_W-1:0]   b,
   input  logic [IN_W-1:0]         c,
   output logic [SUM_W-1:0]        sum,
   input  logic                    arg_start,
   output logic [3:0]              arg_idx,
   output logic                    arg_done
);

   localparam int N1    = N_MAC / 3;
   localparam int N2    = N1 / 3;
   localparam int P_W   = 2 * IN_W + 1;
   localparam int T_W   = MAC_W + 6;
   localparam logic [3:0] LAST = 4'(N_ARG - 1);

   logic [N_MAC*IN_W-1:0] a_reg, b_reg;
   logic [IN_W-1:0]       c_reg;
   logic                  en_reg, acc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg   <= '0;
         b_reg   <= '0;
         c_reg   <= '0;
         en_reg  <= 1'b0;
         acc_reg <= 1'b0;
      end else begin
         a_reg   <= a;
         b_reg   <= b;
         c_reg   <= c;
         en_reg  <= en;
         acc_reg <= acc;
      end
   end

   genvar gi;
   for (gi = 0; gi < N_MAC; gi++) begin : g_lane
      logic signed [P_W-1:0]   dx, bx, prod;
      logic signed [MAC_W-1:0] p_ext, res_reg;

      // Operands widened to the product width so the multiply keeps full precision.
      assign dx = $signed({{(P_W-IN_W){a_reg[gi*IN_W+IN_W-1]}}, a_reg[gi*IN_W +: IN_W]})
                - $signed({{(P_W-IN_W){c_reg[IN_W-1]}}, c_reg});
      assign bx = $signed({{(P_W-IN_W){b_reg[gi*IN_W+IN_W-1]}}, b_reg[gi*IN_W +: IN_W]});
      assign prod  = dx * bx;
      assign p_ext = {{(MAC_W-P_W){prod[P_W-1]}}, prod};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            res_reg <= '0;
         else if (en_reg)
            res_reg <= acc_reg ? res_reg + p_ext : p_ext;
      end
   end

   for (gi = 0; gi < N1; gi++) begin : g_l1
      logic signed [T_W-1:0] sum_reg;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            sum_reg <= '0;
         else
            sum_reg <= {{(T_W-MAC_W){g_lane[3*gi].res_reg[MAC_W-1]}},   g_lane[3*gi].res_reg}
                     + {{(T_W-MAC_W){g_lane[3*gi+1].res_reg[MAC_W-1]}}, g_lane[3*gi+1].res_reg}
                     + {{(T_W-MAC_W){g_lane[3*gi+2].res_reg[MAC_W-1]}}, g_lane[3*gi+2].res_reg};
      end
   end

   for (gi = 0; gi < N2; gi++) begin : g_l2
      logic signed [T_W-1:0] sum_reg;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            sum_reg <= '0;
         else
            sum_reg <= g_l1[3*gi].sum_reg + g_l1[3*gi+1].sum_reg + g_l1[3*gi+2].sum_reg;
      end
   end

   logic signed [T_W-1:0] l3_reg;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         l3_reg <= '0;
      else
         l3_reg <= g_l2[0].sum_reg + g_l2[1].sum_reg + g_l2[2].sum_reg;
   end

   assign sum = l3_reg[SUM_W-1:0];

   // Argmax: snapshot on start, then one compare per clock over the snapshot.
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state_reg, state_next;

   logic signed [IN_W-1:0] snap_reg [N_ARG];
   logic signed [IN_W-1:0] best_reg;
   logic [3:0]             k_reg, idx_reg;
   logic                   done_reg;
   logic                   load, step, last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE: if (arg_start) state_next = SCAN;
         SCAN:       if (k_reg == LAST) state_next = DONE;
         default:    state_next = IDLE;
      endcase
   end

   always_comb begin
      load = (state_reg != SCAN) && arg_start;
      step = (state_reg == SCAN);
      last = step && (k_reg == LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ARG; i++) snap_reg[i] <= '0;
         best_reg <= '0;
         k_reg    <= '0;
         idx_reg  <= '0;
         done_reg <= 1'b0;
      end else if (load) begin
         for (int i = 0; i < N_ARG; i++) snap_reg[i] <= a[i*IN_W +: IN_W];
         best_reg <= a[IN_W-1:0];
         k_reg    <= 4'd1;
         idx_reg  <= 4'd0;
         done_reg <= 1'b0;
      end else if (step) begin
         // Strict compare keeps the lowest index on ties.
         if (snap_reg[k_reg] > best_reg) begin
            best_reg <= snap_reg[k_reg];
            idx_reg  <= k_reg;
         end
         if (last) done_reg <= 1'b1;
         else      k_reg    <= k_reg + 4'd1;
      end
   end

   assign arg_idx  = idx_reg;
   assign arg_done = done_reg;

endmodule

// File: tb/tb_mac_argmax_core.sv
// Directed bench for mac_argmax_core: MAC pipeline latency/accumulate and
// argmax timing, ties, snapshot and control behaviour.
module tb_mac_argmax_core;

   localparam int N_MAC = 27;
   localparam int IN_W  = 8;
   localparam int SUM_W = 24;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  en = 1'b0, acc = 1'b0, arg_start = 1'b0;
   logic [N_MAC*IN_W-1:0] a = '0, b = '0;
   logic [IN_W-1:0]       c = '0;
   logic [SUM_W-1:0]      sum;
   logic [3:0]            arg_idx;
   logic                  arg_done;

   int n_cmp = 0;
   int n_bad = 0;
   int arg_vals [10];

   mac_argmax_core dut (
      .clk(clk), .rst_n(rst_n), .en(en), .acc(acc), .a(a), .b(b), .c(c),
      .sum(sum), .arg_start(arg_start), .arg_idx(arg_idx), .arg_done(arg_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   function automatic longint sum_s();
      return longint'($signed(sum));
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_uniform(input int av, input int bv, input int cv);
      for (int i = 0; i < N_MAC; i++) begin
         a[i*IN_W +: IN_W] = IN_W'(av);
         b[i*IN_W +: IN_W] = IN_W'(bv);
      end
      c = IN_W'(cv);
   endtask

   task automatic load_arg_vals();
      a = '0;
      for (int i = 0; i < 10; i++) a[i*IN_W +: IN_W] = IN_W'(arg_vals[i]);
   endtask

   // Pulse start, scramble lanes after the sampling edge, check done timing and index.
   task automatic run_argmax(input string tag, input int exp_idx);
      load_arg_vals();
      arg_start = 1'b1;
      tick(1);
      arg_start = 1'b0;
      for (int i = 0; i < N_MAC; i++) a[i*IN_W +: IN_W] = IN_W'($urandom);
      chk({tag, " done_low_after_start"}, longint'(arg_done), 0);
      tick(8);
      chk({tag, " done_low_edge8"}, longint'(arg_done), 0);
      tick(1);
      chk({tag, " done_edge9"}, longint'(arg_done), 1);
      chk({tag, " idx"}, longint'(arg_idx), longint'(exp_idx));
   endtask

   typedef struct { int av; int cv; int bv; longint exp; } vec_t;
   vec_t vecs [7];

   initial begin
      vecs[0] = '{1, 0, 1, 27};
      vecs[1] = '{2, 0, 3, 162};
      vecs[2] = '{-5, 3, 7, -1512};
      vecs[3] = '{100, -100, 2, 10800};
      vecs[4] = '{0, 0, 5, 0};
      vecs[5] = '{-1, 0, -1, 27};
      vecs[6] = '{127, -128, 127, 874395};

      // Reset with random inputs
      a = {7{$urandom}}; b = {7{$urandom}}; c = IN_W'($urandom);
      en = 1'b1; acc = 1'b1; arg_start = 1'b1;
      tick(3);
      chk("reset sum", sum_s(), 0);
      chk("reset arg_idx", longint'(arg_idx), 0);
      chk("reset arg_done", longint'(arg_done), 0);
      en = 1'b0; arg_start = 1'b0;
      rst_n = 1'b1;
      tick(6);
      chk("post-reset en=0 sum", sum_s(), 0);

      // Single product
      set_uniform(10, 3, -2); en = 1'b1; acc = 1'b0;
      tick(1);
      en = 1'b0;
      tick(3);
      chk("single edge t+3 not yet", sum_s(), 0);
      tick(1);
      chk("single product", sum_s(), 972);
      tick(3);
      chk("single product hold", sum_s(), 972);

      // Accumulate: overwrite then two accumulates
      en = 1'b1; acc = 1'b0;
      tick(1);
      acc = 1'b1;
      tick(2);
      en = 1'b0;
      tick(4);
      chk("accumulate x3", sum_s(), 2916);

      // Overwrite clears the accumulation
      set_uniform(1, 1, 0); en = 1'b1; acc = 1'b0;
      tick(1);
      en = 1'b0;
      tick(4);
      chk("overwrite clear", sum_s(), 27);

      // Extremes
      set_uniform(-128, -128, 127); en = 1'b1; acc = 1'b0;
      tick(1);
      en = 1'b0;
      tick(4);
      chk("extremes", sum_s(), 881280);

      // Back-to-back streaming
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc >= 5) chk($sformatf("stream v%0d", cyc - 5), sum_s(), vecs[cyc-5].exp);
         if (cyc < 7) begin
            set_uniform(vecs[cyc].av, vecs[cyc].bv, vecs[cyc].cv);
            en = 1'b1; acc = 1'b0;
         end else begin
            en = 1'b0;
         end
         tick(1);
      end

      // Argmax: ties to lowest, all equal, last lane
      arg_vals = '{5, -3, 7, 7, 0, 0, 0, 0, 0, 0};
      run_argmax("argmax tie", 2);
      tick(3);
      chk("argmax sticky done", longint'(arg_done), 1);
      chk("argmax sticky idx", longint'(arg_idx), 2);
      arg_vals = '{42, 42, 42, 42, 42, 42, 42, 42, 42, 42};
      run_argmax("argmax equal", 0);
      arg_vals = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -1};
      run_argmax("argmax last", 9);

      // arg_start during SCAN is ignored
      arg_vals = '{0, 1, 2, 3, 50, 4, 5, 6, 7, 8};
      load_arg_vals();
      arg_start = 1'b1;
      tick(1);
      arg_start = 1'b0;
      tick(3);
      a[7*IN_W +: IN_W] = 8'd100;
      arg_start = 1'b1;
      tick(1);
      arg_start = 1'b0;
      tick(4);
      chk("scan restart ignored done_low", longint'(arg_done), 0);
      tick(1);
      chk("scan restart ignored done", longint'(arg_done), 1);
      chk("scan restart ignored idx", longint'(arg_idx), 4);

      // Reset at scan edge 4
      arg_vals = '{0, 0, 9, 0, 0, 0, 0, 0, 0, 0};
      load_arg_vals();
      arg_start = 1'b1;
      tick(1);
      arg_start = 1'b0;
      tick(4);
      chk("midscan idx before reset", longint'(arg_idx), 2);
      rst_n = 1'b0;
      #1;
      chk("midscan reset arg_done", longint'(arg_done), 0);
      chk("midscan reset arg_idx", longint'(arg_idx), 0);
      chk("midscan reset sum", sum_s(), 0);
      tick(1);
      rst_n = 1'b1;
      tick(2);

      // From IDLE to DONE, then a fresh start from DONE
      arg_vals = '{1, 2, 3, 4, 5, 6, 20, 7, 8, 9};
      run_argmax("argmax after reset", 6);
      arg_vals = '{-7, 30, -2, 11, 0, 29, 3, 1, 4, 30};
      run_argmax("argmax from done", 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
